// File: rtl/alarm_annunciator_if.sv
// Alarm annunciator signal bundle: trigger/ack/snooze requests in, buzzer and status out.
// Latency: none (wires only).
// Backpressure: none; pulses and levels are consumed as presented.
interface alarm_annunciator_if;
  logic       alarm_trig;
  logic       ack;
  logic       snooze;
  logic       buzz_out;
  logic       ringing;
  logic       snoozed;
  logic [3:0] snooze_left;

  // Timer/UI side: raises the alarm and delivers the button pulses.
  modport master (
    output alarm_trig, ack, snooze,
    input  buzz_out, ringing, snoozed, snooze_left
  );

  // Annunciator side.
  modport slave (
    input  alarm_trig, ack, snooze,
    output buzz_out, ringing, snoozed, snooze_left
  );
endinterface

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: beep bursts on a latched alarm level, with snooze countdown and dismiss.
// Latency: buzz_out rises 1 cycle after alarm_trig is sampled high; outputs are Moore.
// Backpressure: none; ack/snooze are single-cycle pulses. Option macro: ANNUNC_SNOOZE_LIMIT_EN.
module alarm_annunciator #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int BEEP_ON_MS     = 200,
  parameter int BEEP_OFF_MS    = 300,
  parameter int BURST_BEEPS    = 4,
  parameter int GAP_MS         = 1000,
  parameter int SNOOZE_S       = 9,
  parameter int TIMEOUT_BURSTS = 20
) (
  input  logic             clk,
  input  logic             resetn,
  alarm_annunciator_if.slave bus
);

  localparam int TICK    = CLK_HZ / 1000;
  localparam int PS_W    = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int MS_MAX1 = (BEEP_ON_MS > BEEP_OFF_MS) ? BEEP_ON_MS : BEEP_OFF_MS;
  localparam int MS_MAX2 = (MS_MAX1 > GAP_MS) ? MS_MAX1 : GAP_MS;
  localparam int MS_MAX  = (MS_MAX2 > 1000) ? MS_MAX2 : 1000;
  localparam int MS_W    = $clog2(MS_MAX);
  localparam int BEEP_W  = $clog2(BURST_BEEPS + 1);
  localparam int BURST_W = $clog2(TIMEOUT_BURSTS + 1);

  localparam logic [PS_W-1:0]    PS_LAST   = PS_W'(TICK - 1);
  localparam logic [MS_W-1:0]    ON_LAST   = MS_W'(BEEP_ON_MS - 1);
  localparam logic [MS_W-1:0]    OFF_LAST  = MS_W'(BEEP_OFF_MS - 1);
  localparam logic [MS_W-1:0]    GAP_LAST  = MS_W'(GAP_MS - 1);
  localparam logic [MS_W-1:0]    SEC_LAST  = MS_W'(999);
  localparam logic [BEEP_W-1:0]  BEEP_MAX  = BEEP_W'(BURST_BEEPS);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(TIMEOUT_BURSTS);
  localparam logic [3:0]         SNZ_INIT  = 4'(SNOOZE_S);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RING_ON  = 3'd1,
    RING_OFF = 3'd2,
    GAP      = 3'd3,
    SNOOZE   = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t              state, next_state;
  logic [PS_W-1:0]     ps_cnt;
  logic [MS_W-1:0]     ms_cnt;
  logic [MS_W-1:0]     phase_last;
  logic [BEEP_W-1:0]   beep_cnt;
  logic [BURST_W-1:0]  burst_cnt;
  logic [3:0]          snz_left;
  logic                phase_done;
  logic                ring_st;
  logic                snooze_ok;

  assign ring_st = (state == RING_ON) || (state == RING_OFF) || (state == GAP);

`ifdef ANNUNC_SNOOZE_LIMIT_EN
  logic [1:0] snz_num;

  // After three accepted snoozes in one alarm episode the snooze button stops working.
  assign snooze_ok = bus.snooze && (snz_num != 2'd3);

  // Count accepted snoozes; an episode ends in IDLE.
  always_ff @(posedge clk) begin
    if (!resetn || state == IDLE) begin
      snz_num <= 2'd0;
    end else if (ring_st && next_state == SNOOZE) begin
      snz_num <= snz_num + 2'd1;
    end
  end
`else
  assign snooze_ok = bus.snooze;
`endif

  // Length of the current phase in ms, minus one.
  always_comb begin
    phase_last = '0;
    case (state)
      RING_ON:  phase_last = ON_LAST;
      RING_OFF: phase_last = OFF_LAST;
      GAP:      phase_last = GAP_LAST;
      SNOOZE:   phase_last = SEC_LAST;
      default:  phase_last = '0;
    endcase
  end

  assign phase_done = (ps_cnt == PS_LAST) && (ms_cnt == phase_last);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: trigger loss first, then ack, then snooze, then phase expiry.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.alarm_trig) next_state = RING_ON;
      end
      RING_ON, RING_OFF, GAP: begin
        if (!bus.alarm_trig)   next_state = IDLE;
        else if (bus.ack)      next_state = DONE;
        else if (snooze_ok)    next_state = SNOOZE;
        else if (phase_done) begin
          case (state)
            RING_ON:  next_state = RING_OFF;
            RING_OFF: next_state = (beep_cnt < BEEP_MAX) ? RING_ON : GAP;
            default:  next_state = (burst_cnt == BURST_MAX) ? DONE : RING_ON;
          endcase
        end
      end
      SNOOZE: begin
        if (!bus.alarm_trig)                    next_state = IDLE;
        else if (bus.ack)                       next_state = DONE;
        else if (phase_done && snz_left == 4'd1) next_state = RING_ON;
      end
      DONE: begin
        if (!bus.alarm_trig) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    bus.buzz_out    = (state == RING_ON);
    bus.ringing     = ring_st;
    bus.snoozed     = (state == SNOOZE);
    bus.snooze_left = (state == SNOOZE) ? snz_left : 4'd0;
  end

  // ms prescaler and phase ms counter; restart on every transition and each snooze second.
  always_ff @(posedge clk) begin
    if (!resetn || state != next_state || phase_done || state == IDLE || state == DONE) begin
      ps_cnt <= '0;
      ms_cnt <= '0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
      ms_cnt <= ms_cnt + 1'b1;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // Beeps within the current burst: counted on leaving RING_ON, cleared at burst end/snooze/idle.
  always_ff @(posedge clk) begin
    if (!resetn || next_state == IDLE || next_state == SNOOZE ||
        (state == RING_OFF && next_state == GAP)) begin
      beep_cnt <= '0;
    end else if (state == RING_ON && next_state == RING_OFF) begin
      beep_cnt <= beep_cnt + 1'b1;
    end
  end

  // Completed bursts toward auto-dismiss; a finished snooze starts the count again.
  always_ff @(posedge clk) begin
    if (!resetn || next_state == IDLE || (state == SNOOZE && next_state == RING_ON)) begin
      burst_cnt <= '0;
    end else if (state == RING_OFF && next_state == GAP) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Snooze seconds remaining: loaded on entry, decremented at each whole second.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      snz_left <= 4'd0;
    end else if (state != SNOOZE && next_state == SNOOZE) begin
      snz_left <= SNZ_INIT;
    end else if (state == SNOOZE && next_state == SNOOZE && phase_done) begin
      snz_left <= snz_left - 4'd1;
    end
  end

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed bench for alarm_annunciator at 1 ms per cycle.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Expected vectors are {buzz_out, ringing, snoozed, snooze_left[3:0]}.
module tb_alarm_annunciator;
  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  alarm_annunciator_if bus ();

  alarm_annunciator #(
    .CLK_HZ(1000), .BEEP_ON_MS(2), .BEEP_OFF_MS(3), .BURST_BEEPS(2),
    .GAP_MS(5), .SNOOZE_S(3), .TIMEOUT_BURSTS(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  logic [6:0] outs;
  assign outs = {bus.buzz_out, bus.ringing, bus.snoozed, bus.snooze_left};

  // Buzzer over one burst: two 2 ms beeps with 3 ms off, then 5 ms gap.
  bit pat [15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.alarm_trig = 1'b0; bus.ack = 1'b0; bus.snooze = 1'b0;
    step(); step();
    n_checks++;
    if (outs !== 7'b0000000) begin
      n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, 7'b0000000);
    end
    resetn = 1'b1;
    step();
    n_checks++;
    if (outs !== 7'b0000000) begin
      n_fail++; $display("FAIL idle_outs: got %b expected %b", outs, 7'b0000000);
    end
  endtask

  task automatic test_pattern();
    logic [6:0] e;
    bus.alarm_trig = 1'b1;
    step();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 15; i++) begin
        e = {pat[i], 1'b1, 1'b0, 4'd0};
        n_checks++;
        if (outs !== e) begin
          n_fail++; $display("FAIL pattern b%0d c%0d: got %b expected %b", b, i, outs, e);
        end
        step();
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (outs !== 7'b0000000) begin
        n_fail++; $display("FAIL timeout_done c%0d: got %b expected %b", i, outs, 7'b0000000);
      end
      step();
    end
    bus.alarm_trig = 1'b0;
    step();
    n_checks++;
    if (outs !== 7'b0000000) begin
      n_fail++; $display("FAIL done_to_idle: got %b expected %b", outs, 7'b0000000);
    end
  endtask

  task automatic test_snooze();
    bus.alarm_trig = 1'b1;
    step();
    n_checks++;
    if (outs !== 7'b1100000) begin
      n_fail++; $display("FAIL snz_ring_start: got %b expected %b", outs, 7'b1100000);
    end
    bus.snooze = 1'b1;
    step();
    bus.snooze = 1'b0;
    n_checks++;
    if (outs !== 7'b0010011) begin
      n_fail++; $display("FAIL snz_entry: got %b expected %b", outs, 7'b0010011);
    end
    repeat (999) step();
    n_checks++;
    if (outs !== 7'b0010011) begin
      n_fail++; $display("FAIL snz_999: got %b expected %b", outs, 7'b0010011);
    end
    step();
    n_checks++;
    if (outs !== 7'b0010010) begin
      n_fail++; $display("FAIL snz_1000: got %b expected %b", outs, 7'b0010010);
    end
    repeat (1000) step();
    n_checks++;
    if (outs !== 7'b0010001) begin
      n_fail++; $display("FAIL snz_2000: got %b expected %b", outs, 7'b0010001);
    end
    repeat (999) step();
    n_checks++;
    if (outs !== 7'b0010001) begin
      n_fail++; $display("FAIL snz_2999: got %b expected %b", outs, 7'b0010001);
    end
    step();
    n_checks++;
    if (outs !== 7'b1100000) begin
      n_fail++; $display("FAIL snz_3000_ring: got %b expected %b", outs, 7'b1100000);
    end
    bus.alarm_trig = 1'b0;
    step();
    n_checks++;
    if (outs !== 7'b0000000) begin
      n_fail++; $display("FAIL snz_drop_idle: got %b expected %b", outs, 7'b0000000);
    end
  endtask

  task automatic test_ack_snooze_gap();
    bus.alarm_trig = 1'b1;
    step();
    repeat (10) step();
    n_checks++;
    if (outs !== 7'b0100000) begin
      n_fail++; $display("FAIL gap_reached: got %b expected %b", outs, 7'b0100000);
    end
    bus.ack = 1'b1; bus.snooze = 1'b1;
    step();
    bus.ack = 1'b0; bus.snooze = 1'b0;
    n_checks++;
    if (outs !== 7'b0000000) begin
      n_fail++; $display("FAIL ack_beats_snooze: got %b expected %b", outs, 7'b0000000);
    end
    repeat (3) step();
    n_checks++;
    if (outs !== 7'b0000000) begin
      n_fail++; $display("FAIL done_no_retrigger: got %b expected %b", outs, 7'b0000000);
    end
    bus.alarm_trig = 1'b0;
    step();
    bus.alarm_trig = 1'b1;
    step();
    n_checks++;
    if (outs !== 7'b1100000) begin
      n_fail++; $display("FAIL done_idle_rering: got %b expected %b", outs, 7'b1100000);
    end
  endtask

  task automatic test_drop_ring_off();
    logic [6:0] e;
    repeat (2) step();
    n_checks++;
    if (outs !== 7'b0100000) begin
      n_fail++; $display("FAIL in_ring_off: got %b expected %b", outs, 7'b0100000);
    end
    bus.alarm_trig = 1'b0;
    step();
    n_checks++;
    if (outs !== 7'b0000000) begin
      n_fail++; $display("FAIL drop_idle: got %b expected %b", outs, 7'b0000000);
    end
    bus.alarm_trig = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      e = {pat[i], 1'b1, 1'b0, 4'd0};
      n_checks++;
      if (outs !== e) begin
        n_fail++; $display("FAIL restart c%0d: got %b expected %b", i, outs, e);
      end
      step();
    end
    bus.alarm_trig = 1'b0;
    step();
  endtask

  task automatic test_reset_in_snooze();
    bus.alarm_trig = 1'b1;
    step();
    bus.snooze = 1'b1;
    step();
    bus.snooze = 1'b0;
    n_checks++;
    if (outs !== 7'b0010011) begin
      n_fail++; $display("FAIL rst_snz_entry: got %b expected %b", outs, 7'b0010011);
    end
    repeat (5) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_checks++;
    if (outs !== 7'b0000000) begin
      n_fail++; $display("FAIL rst_in_snooze: got %b expected %b", outs, 7'b0000000);
    end
    step();
    n_checks++;
    if (outs !== 7'b1100000) begin
      n_fail++; $display("FAIL rst_rering: got %b expected %b", outs, 7'b1100000);
    end
  endtask

  task automatic test_snooze_limit();
    logic [6:0] e;
    for (int k = 0; k < 3; k++) begin
      bus.snooze = 1'b1;
      step();
      bus.snooze = 1'b0;
      n_checks++;
      if (outs !== 7'b0010011) begin
        n_fail++; $display("FAIL limit_snz%0d: got %b expected %b", k, outs, 7'b0010011);
      end
      repeat (3000) step();
      n_checks++;
      if (outs !== 7'b1100000) begin
        n_fail++; $display("FAIL limit_ring%0d: got %b expected %b", k, outs, 7'b1100000);
      end
    end
    bus.snooze = 1'b1;
    step();
    bus.snooze = 1'b0;
`ifdef ANNUNC_SNOOZE_LIMIT_EN
    e = 7'b1100000;
`else
    e = 7'b0010011;
`endif
    n_checks++;
    if (outs !== e) begin
      n_fail++; $display("FAIL limit_fourth: got %b expected %b", outs, e);
    end
    bus.alarm_trig = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn = 1'b0;
    bus.alarm_trig = 1'b0; bus.ack = 1'b0; bus.snooze = 1'b0;
    test_reset();
    test_pattern();
    test_snooze();
    test_ack_snooze_gap();
    test_drop_ring_off();
    test_reset_in_snooze();
    test_snooze_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
